sram_burst_ctrl: RTL and testbench

Initiator-side controller for the single-port synchronous `sram` (2^12 × 16) in the CPU memory subsystem. It accepts burst read/write requests from the core or a DMA agent over a valid/ready handshake and sequences the SRAM `i_ce`/`i_we`/`i_addr`/`i_data` pins one word per cycle. It also captures the SRAM's one-cycle-latency read data and returns it as a valid-qualified stream with a last flag.

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_burst_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller.
//   - default address / word / burst-length widths
//   - FSM state encoding
package sram_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_LEN_WIDTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WLAST,
        ST_READ,
        ST_RDRAIN,
        ST_RLAST
    } state_t;

endpackage

// File: rtl/sram_burst_ctrl.sv
// Burst read/write controller for a single-port synchronous SRAM with
// one-cycle read latency. Sequences one SRAM word per cycle.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   i_req_* / o_req_ready           burst request handshake (len = words-1)
//   i_wdata_valid/o_wdata_ready     write beat handshake, i_wdata beat
//   o_rdata_valid/o_rdata/_last     read beat stream, no backpressure
//   o_done                          one-cycle pulse at burst completion
//   o_sram_ce/we/addr/data          registered SRAM pins
//   i_sram_data                     SRAM read data
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a request
// ST_WRITE  | accepting write beats, one SRAM write per accepted beat
// ST_WLAST  | final write on the SRAM pins, o_done
// ST_READ   | issuing reads start..start+len, one per cycle
// ST_RDRAIN | hold last read on pins so SRAM keeps driving the last word
// ST_RLAST  | last read beat out with o_rdata_last, o_done
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [LEN_WIDTH-1:0]  i_req_len,
    input  logic                  i_wdata_valid,
    output logic                  o_wdata_ready,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    output logic                  o_rdata_valid,
    output logic [WORD_WIDTH-1:0] o_rdata,
    output logic                  o_rdata_last,
    output logic                  o_done,
    output logic                  o_sram_ce,
    output logic                  o_sram_we,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [WORD_WIDTH-1:0] o_sram_data,
    input  logic [WORD_WIDTH-1:0] i_sram_data
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  ce_d, we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [WORD_WIDTH-1:0] data_d;
    logic                  capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_cnt_d    = addr_cnt_q;
        beat_d        = beat_q;
        len_d         = len_q;
        ce_d          = 1'b0;
        we_d          = 1'b0;
        addr_d        = o_sram_addr;
        data_d        = o_sram_data;
        capture       = 1'b0;
        o_req_ready   = 1'b0;
        o_wdata_ready = 1'b0;
        o_done        = 1'b0;
        o_rdata_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    len_d  = i_req_len;
                    beat_d = '0;
                    if (i_req_we) begin
                        state_d    = ST_WRITE;
                        addr_cnt_d = i_req_addr;
                    end else begin
                        // First read goes out straight from the request.
                        state_d    = ST_READ;
                        ce_d       = 1'b1;
                        addr_d     = i_req_addr;
                        addr_cnt_d = i_req_addr + ADDR_WIDTH'(1);
                    end
                end
            end

            ST_WRITE: begin
                o_wdata_ready = 1'b1;
                if (i_wdata_valid) begin
                    ce_d       = 1'b1;
                    we_d       = 1'b1;
                    addr_d     = addr_cnt_q;
                    data_d     = i_wdata;
                    addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                    if (beat_q == len_q) begin
                        state_d = ST_WLAST;
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
            end

            ST_WLAST: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end

            ST_READ: begin
                ce_d = 1'b1;
                // beat_q counts reads already on the pins; data for the
                // previous one is on i_sram_data from the second cycle on.
                capture = (beat_q != '0);
                if (beat_q == len_q) begin
                    state_d = ST_RDRAIN;
                end else begin
                    addr_d     = addr_cnt_q;
                    addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                    beat_d     = beat_q + LEN_WIDTH'(1);
                end
            end

            ST_RDRAIN: begin
                capture = 1'b1;
                state_d = ST_RLAST;
            end

            ST_RLAST: begin
                o_rdata_last = 1'b1;
                o_done       = 1'b1;
                state_d      = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_cnt_q    <= '0;
            beat_q        <= '0;
            len_q         <= '0;
            o_sram_ce     <= 1'b0;
            o_sram_we     <= 1'b0;
            o_sram_addr   <= '0;
            o_sram_data   <= '0;
            o_rdata_valid <= 1'b0;
            o_rdata       <= '0;
        end else begin
            addr_cnt_q    <= addr_cnt_d;
            beat_q        <= beat_d;
            len_q         <= len_d;
            o_sram_ce     <= ce_d;
            o_sram_we     <= we_d;
            o_sram_addr   <= addr_d;
            o_sram_data   <= data_d;
            o_rdata_valid <= capture;
            if (capture) begin
                o_rdata <= i_sram_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
module tb_sram_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, i_req_we;
    logic [11:0] i_req_addr;
    logic [7:0]  i_req_len;
    logic        i_wdata_valid;
    logic [15:0] i_wdata;
    logic        o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata_last, o_done;
    logic [15:0] o_rdata;
    logic        o_sram_ce, o_sram_we;
    logic [11:0] o_sram_addr;
    logic [15:0] o_sram_data, i_sram_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_mem [0:4095];
    logic [15:0] wq [$];

    always #5 clk = ~clk;

    sram_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
        .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
        .o_rdata_valid(o_rdata_valid), .o_rdata(o_rdata), .o_rdata_last(o_rdata_last),
        .o_done(o_done),
        .o_sram_ce(o_sram_ce), .o_sram_we(o_sram_we),
        .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data),
        .i_sram_data(i_sram_data)
    );

    // SRAM behavioural model: synchronous, one-cycle read latency,
    // output driven only while ce & !we.
    logic [15:0] mem [0:4095];
    logic [15:0] sram_q;
    always @(posedge clk) begin
        if (o_sram_ce) begin
            if (o_sram_we) mem[o_sram_addr] <= o_sram_data;
            else           sram_q <= mem[o_sram_addr];
        end
    end
    assign i_sram_data = (o_sram_ce && !o_sram_we) ? sram_q : 16'h0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [11:0] addr, input int len,
                            input logic [7:0] bubbles, input int exp_low);
        int beat, ce_low;
        bit prev_acc, bub;
        logic [11:0] ea;
        logic [15:0] ed;
        beat = 0; ce_low = 0; prev_acc = 0; bub = 0; ea = '0; ed = '0;
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = addr; i_req_len = len[7:0];
        n_checks++; if (o_req_ready !== 1'b1) $display("FAIL wr_req_ready: got %b want 1", o_req_ready); else n_pass++;
        step();
        i_req_valid = 1'b0;
        while (beat <= len) begin
            n_checks++; if (o_sram_ce !== prev_acc) $display("FAIL wr_ce: got %b want %b", o_sram_ce, prev_acc); else n_pass++;
            if (prev_acc) begin
                n_checks++; if (o_sram_we !== 1'b1 || o_sram_addr !== ea || o_sram_data !== ed)
                    $display("FAIL wr_pins: got we=%b a=%h d=%h want we=1 a=%h d=%h", o_sram_we, o_sram_addr, o_sram_data, ea, ed);
                else n_pass++;
            end
            if (beat > 0 && o_sram_ce === 1'b0) ce_low++;
            n_checks++; if (o_wdata_ready !== 1'b1 || o_done !== 1'b0)
                $display("FAIL wr_busy_flags: got wready=%b done=%b want 1 0", o_wdata_ready, o_done);
            else n_pass++;
            if (bub) begin
                i_wdata_valid = 1'b0; prev_acc = 0; bub = 0;
            end else begin
                i_wdata_valid = 1'b1; i_wdata = wq[beat];
                ea = addr + beat[11:0]; ed = wq[beat];
                exp_mem[ea] = ed; prev_acc = 1;
                bub = (beat < 8) && bubbles[beat[2:0]];
                beat++;
            end
            step();
        end
        i_wdata_valid = 1'b0;
        n_checks++; if (o_sram_ce !== 1'b1 || o_sram_we !== 1'b1 || o_sram_addr !== ea || o_sram_data !== ed)
            $display("FAIL wr_last_pins: got ce=%b we=%b a=%h d=%h want 1 1 %h %h", o_sram_ce, o_sram_we, o_sram_addr, o_sram_data, ea, ed);
        else n_pass++;
        n_checks++; if (o_done !== 1'b1 || o_wdata_ready !== 1'b0 || o_req_ready !== 1'b0)
            $display("FAIL wr_done: got done=%b wready=%b rready=%b want 1 0 0", o_done, o_wdata_ready, o_req_ready);
        else n_pass++;
        step();
        n_checks++; if (o_req_ready !== 1'b1 || o_done !== 1'b0 || o_sram_ce !== 1'b0)
            $display("FAIL wr_end: got rready=%b done=%b ce=%b want 1 0 0", o_req_ready, o_done, o_sram_ce);
        else n_pass++;
        n_checks++; if (ce_low != exp_low) $display("FAIL wr_bubbles: got %0d want %0d", ce_low, exp_low); else n_pass++;
    endtask

    task automatic do_read(input logic [11:0] addr, input int len, input int busy_at);
        int beats, k;
        logic exp_v, exp_ce;
        logic [11:0] ea;
        beats = 0;
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = addr; i_req_len = len[7:0];
        n_checks++; if (o_req_ready !== 1'b1) $display("FAIL rd_req_ready: got %b want 1", o_req_ready); else n_pass++;
        step();
        i_req_valid = 1'b0;
        i_wdata_valid = 1'b1; i_wdata = 16'hDEAD;
        for (int cyc = 1; cyc <= len + 4; cyc++) begin
            exp_v = (cyc >= 3 && cyc <= len + 3);
            n_checks++; if (o_rdata_valid !== exp_v) $display("FAIL rd_valid c%0d: got %b want %b", cyc, o_rdata_valid, exp_v); else n_pass++;
            n_checks++; if (o_rdata_last !== (cyc == len + 3) || o_done !== (cyc == len + 3))
                $display("FAIL rd_last_done c%0d: got last=%b done=%b want %b", cyc, o_rdata_last, o_done, (cyc == len + 3));
            else n_pass++;
            n_checks++; if (o_req_ready !== (cyc == len + 4) || o_wdata_ready !== 1'b0)
                $display("FAIL rd_ready c%0d: got rready=%b wready=%b want %b 0", cyc, o_req_ready, o_wdata_ready, (cyc == len + 4));
            else n_pass++;
            if (exp_v) begin
                k = cyc - 3; ea = addr + k[11:0]; beats++;
                n_checks++; if (o_rdata !== exp_mem[ea]) $display("FAIL rd_data beat %0d: got %h want %h", k, o_rdata, exp_mem[ea]); else n_pass++;
            end
            exp_ce = (cyc <= len + 2);
            n_checks++; if (o_sram_ce !== exp_ce) $display("FAIL rd_ce c%0d: got %b want %b", cyc, o_sram_ce, exp_ce); else n_pass++;
            if (exp_ce) begin
                k = (cyc - 1 < len) ? cyc - 1 : len; ea = addr + k[11:0];
                n_checks++; if (o_sram_we !== 1'b0 || o_sram_addr !== ea)
                    $display("FAIL rd_pins c%0d: got we=%b a=%h want 0 %h", cyc, o_sram_we, o_sram_addr, ea);
                else n_pass++;
            end
            if (cyc == busy_at) begin
                i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 12'h555; i_req_len = 8'd0;
                n_checks++; if (o_req_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", o_req_ready); else n_pass++;
            end else begin
                i_req_valid = 1'b0;
            end
            if (cyc < len + 4) step();
        end
        i_wdata_valid = 1'b0;
        n_checks++; if (beats != len + 1) $display("FAIL rd_beats: got %0d want %0d", beats, len + 1); else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++; if (o_req_ready !== 1'b1 || o_wdata_ready !== 1'b0 || o_rdata_valid !== 1'b0 || o_rdata !== 16'h0 ||
                        o_rdata_last !== 1'b0 || o_done !== 1'b0 || o_sram_ce !== 1'b0 || o_sram_we !== 1'b0 ||
                        o_sram_addr !== 12'h0 || o_sram_data !== 16'h0)
            $display("FAIL reset_vals: got rr=%b wr=%b rv=%b rd=%h rl=%b dn=%b ce=%b we=%b a=%h d=%h want 1 and rest 0",
                     o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata, o_rdata_last, o_done, o_sram_ce, o_sram_we, o_sram_addr, o_sram_data);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++; if (o_req_ready !== 1'b1 || o_sram_ce !== 1'b0) $display("FAIL reset_release: got rr=%b ce=%b want 1 0", o_req_ready, o_sram_ce); else n_pass++;
    endtask

    task automatic test_single();
        wq = '{16'hBEEF};
        do_write(12'h010, 0, 8'h00, 0);
        n_checks++; if (mem[12'h010] !== 16'hBEEF) $display("FAIL single_mem: got %h want beef", mem[12'h010]); else n_pass++;
        do_read(12'h010, 0, 0);
        n_checks++; if (o_rdata !== 16'hBEEF) $display("FAIL single_rdata_hold: got %h want beef", o_rdata); else n_pass++;
    endtask

    task automatic test_full_burst();
        wq = {};
        for (int i = 0; i < 256; i++) wq.push_back(i[15:0]);
        do_write(12'h100, 255, 8'h00, 0);
        n_checks++; if (mem[12'h1FF] !== 16'h00FF) $display("FAIL full_mem_top: got %h want 00ff", mem[12'h1FF]); else n_pass++;
        do_read(12'h100, 255, 0);
    endtask

    task automatic test_write_bubbles();
        wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_write(12'h200, 3, 8'b0000_0011, 2);
        for (int i = 0; i < 4; i++) begin
            logic [11:0] a;
            a = 12'h200 + i[11:0];
            n_checks++; if (mem[a] !== wq[i]) $display("FAIL bubble_mem %h: got %h want %h", a, mem[a], wq[i]); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        wq = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        do_write(12'hFFE, 3, 8'h00, 0);
        n_checks++; if (mem[12'hFFE] !== 16'hAAAA || mem[12'hFFF] !== 16'hBBBB || mem[12'h000] !== 16'hCCCC || mem[12'h001] !== 16'hDDDD)
            $display("FAIL wrap_mem: got %h %h %h %h want aaaa bbbb cccc dddd", mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]);
        else n_pass++;
        do_read(12'hFFE, 3, 0);
    endtask

    task automatic test_busy_request();
        wq = '{16'h1234};
        do_write(12'h555, 0, 8'h00, 0);
        do_read(12'h100, 3, 2);
        // new request raised exactly in cycle L+4 of the previous read
        do_read(12'h200, 3, 0);
        n_checks++; if (mem[12'h555] !== 16'h1234) $display("FAIL busy_ignored: got %h want 1234", mem[12'h555]); else n_pass++;
    endtask

    task automatic test_mid_reset();
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 12'h100; i_req_len = 8'd7;
        step();
        i_req_valid = 1'b0;
        step();
        step();
        n_checks++; if (o_sram_ce !== 1'b1 || o_sram_addr !== 12'h102) $display("FAIL mr_beat2: got ce=%b a=%h want 1 102", o_sram_ce, o_sram_addr); else n_pass++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++; if (o_req_ready !== 1'b1 || o_wdata_ready !== 1'b0 || o_rdata_valid !== 1'b0 || o_rdata !== 16'h0 ||
                        o_rdata_last !== 1'b0 || o_done !== 1'b0 || o_sram_ce !== 1'b0 || o_sram_we !== 1'b0 ||
                        o_sram_addr !== 12'h0 || o_sram_data !== 16'h0)
            $display("FAIL mr_reset_vals: got rr=%b rv=%b rd=%h dn=%b ce=%b a=%h want 1 0 0 0 0 0",
                     o_req_ready, o_rdata_valid, o_rdata, o_done, o_sram_ce, o_sram_addr);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++; if (o_done !== 1'b0 || o_rdata_valid !== 1'b0 || o_sram_ce !== 1'b0)
                $display("FAIL mr_quiet %0d: got done=%b rv=%b ce=%b want 0 0 0", i, o_done, o_rdata_valid, o_sram_ce);
            else n_pass++;
        end
        do_read(12'h010, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0; i_req_len = '0;
        i_wdata_valid = 1'b0; i_wdata = '0;
        for (int i = 0; i < 4096; i++) exp_mem[i] = 16'h0;
        test_reset();
        test_single();
        test_full_burst();
        test_write_bubbles();
        test_wrap();
        test_busy_request();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
